// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture sequencer.
package adc_capture_pkg;

    localparam int ADC_W = 12;
    localparam logic [ADC_W-1:0] ADC_MID = 12'd2048;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN
    } cap_state_t;

    // Distance from mid-scale; 0 maps to 2048 and 4095 to 2047, so no wrap.
    function automatic logic [ADC_W-1:0] abs_dev(input logic [ADC_W-1:0] s);
        return (s >= ADC_MID) ? (s - ADC_MID) : (ADC_MID - s);
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// First-word-fall-through sample buffer with synchronous flush.
module adc_sample_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign valid   = (count != '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_rd   = rd_en && valid;
    // A write into a full buffer is legal only when a word leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered window capture of the ADC sample stream into a valid/ready output.
// Optional arm timeout enabled by defining ADC_CAPTURE_TIMEOUT_EN.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int          LEN_W       = 16,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd81_360_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adc_data_en,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [ADC_W-1:0] cmd_thresh,
    input  logic             abort,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ADC_W-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             timeout
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    cap_state_t       state;
    logic [LEN_W-1:0] rem;
    logic [ADC_W-1:0] thr;
`ifdef ADC_CAPTURE_TIMEOUT_EN
    logic [31:0]      tmr;
`endif

    logic             flush;
    logic             trig;
    logic             sample_in;
    logic             last_tag;
    logic             pop;
    logic             can_push;
    logic             push;
    logic             drop;
    logic             drain_done;
    logic             fifo_valid;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [ADC_W:0]   fifo_dout;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign m_valid   = fifo_valid;
    assign m_data    = fifo_dout[ADC_W-1:0];
    assign m_last    = fifo_dout[ADC_W];

    assign flush      = abort && (state != IDLE);
    assign trig       = (state == ARMED) && adc_data_en && (abs_dev(adc_data) >= thr);
    // Abort beats any same-cycle trigger or push.
    assign sample_in  = !flush && (trig || ((state == CAPTURE) && adc_data_en));
    assign last_tag   = (rem == LEN_W'(1));
    assign pop        = fifo_valid && m_ready;
    assign can_push   = !fifo_full || pop;
    assign push       = sample_in && can_push;
    assign drop       = sample_in && !can_push;
    assign drain_done = (fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop);

    adc_sample_fifo #(
        .WIDTH (ADC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (push),
        .wr_data ({last_tag, adc_data}),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .valid   (fifo_valid),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            thr      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
            timeout  <= 1'b0;
            tmr      <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (drop) overflow <= 1'b1;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            rem      <= cmd_len;
                            thr      <= cmd_thresh;
                            overflow <= 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
                            timeout  <= 1'b0;
                            tmr      <= '0;
`endif
                            if (cmd_len == '0) done  <= 1'b1;
                            else               state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (trig) begin
                            rem   <= rem - LEN_W'(1);
                            state <= last_tag ? DRAIN : CAPTURE;
                        end
`ifdef ADC_CAPTURE_TIMEOUT_EN
                        else if (tmr == TIMEOUT_CYC - 32'd1) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            tmr <= tmr + 32'd1;
                        end
`endif
                    end
                    CAPTURE: begin
                        if (adc_data_en) begin
                            rem <= rem - LEN_W'(1);
                            if (last_tag) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (drain_done) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef ADC_CAPTURE_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed and randomized bench for adc_capture_ctrl against a queue-based window model.
module tb_adc_capture_ctrl;

    localparam int TO = 100;
`ifdef ADC_CAPTURE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_data_en;
    logic [11:0] adc_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [11:0] cmd_thresh;
    logic        abort;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        timeout;

    always #5 clk = ~clk;

    adc_capture_ctrl #(
        .LEN_W       (16),
        .FIFO_DEPTH  (16),
        .TIMEOUT_CYC (32'd100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adc_data_en (adc_data_en),
        .adc_data    (adc_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .cmd_thresh  (cmd_thresh),
        .abort       (abort),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    int tests = 0;
    int fails = 0;

    // Window model: ph 0 idle, 1 waiting for trigger, 2 collecting, 3 emptying.
    int          ph = 0;
    logic [12:0] q[$];
    logic [12:0] got[$];
    int          rem_m = 0;
    int          thr_m = 0;
    int          tmr_m = 0;
    bit          ovf_m = 1'b0;
    bit          tout_m = 1'b0;
    bit          done_m = 1'b0;
    int          done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs late in the cycle, advance the model with this cycle's inputs, then cross the edge.
    task automatic cycle();
        int sz0;
        bit pop;
        bit smp;
        int a;
        int dev;
        #4;
        chk("m_valid", m_valid, q.size() != 0);
        if (q.size() != 0) chk("m_word", {m_last, m_data}, q[0]);
        chk("busy", busy, ph != 0);
        chk("cmd_ready", cmd_ready, ph == 0);
        chk("done", done, done_m);
        chk("overflow", overflow, ovf_m);
        chk("timeout", timeout, tout_m);
        if (done_m) done_cnt++;
        sz0 = q.size();
        pop = (sz0 != 0) && m_ready;
        if (pop) begin
            got.push_back(q[0]);
            void'(q.pop_front());
        end
        done_m = 1'b0;
        smp = 1'b0;
        a = int'(adc_data);
        dev = (a >= 2048) ? a - 2048 : 2048 - a;
        if (ph != 0 && abort) begin
            q.delete();
            ph = 0;
        end else begin
            case (ph)
                0: if (cmd_valid) begin
                    rem_m = int'(cmd_len);
                    thr_m = int'(cmd_thresh);
                    ovf_m = 1'b0;
                    tout_m = 1'b0;
                    tmr_m = 0;
                    if (cmd_len == 0) done_m = 1'b1;
                    else ph = 1;
                end
                1: if (adc_data_en && dev >= thr_m) smp = 1'b1;
                   else if (TO_EN && tmr_m == TO - 1) begin
                       tout_m = 1'b1;
                       ph = 0;
                   end else tmr_m++;
                2: if (adc_data_en) smp = 1'b1;
                3: if (q.size() == 0) begin
                    done_m = 1'b1;
                    ph = 0;
                end
                default: ph = 0;
            endcase
        end
        if (smp) begin
            if (sz0 < 16 || pop) q.push_back({rem_m == 1, adc_data});
            else ovf_m = 1'b1;
            rem_m--;
            ph = (rem_m == 0) ? 3 : 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int len, input int th);
        cmd_valid = 1'b1;
        cmd_len = 16'(len);
        cmd_thresh = 12'(th);
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic sample(input int d);
        adc_data_en = 1'b1;
        adc_data = 12'(d);
        cycle();
        adc_data_en = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while ((ph != 0 || done_m) && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        int d0;
        logic [12:0] w;
        rst = 1'b1;
        adc_data_en = 1'b0;
        adc_data = '0;
        cmd_valid = 1'b0;
        cmd_len = '0;
        cmd_thresh = '0;
        abort = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 12'd0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Immediate trigger: four samples out, last tagged, fifth ignored.
        got.delete();
        d0 = done_cnt;
        m_ready = 1'b1;
        cmd(4, 0);
        for (int i = 1; i <= 5; i++) sample(i * 100);
        run_until_idle("imm_idle", 40);
        chk("imm_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("imm_word", got[i], {(i == 3) ? 1'b1 : 1'b0, 12'((i + 1) * 100)});
        chk("imm_done", done_cnt - d0, 1);

        // Threshold trigger on 1500 (deviation 548).
        got.delete();
        cmd(2, 500);
        sample(2048); sample(2400); sample(1500); sample(2700); sample(3000);
        run_until_idle("thr_idle", 40);
        chk("thr_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("thr_w0", got[0], {1'b0, 12'd1500});
            chk("thr_w1", got[1], {1'b1, 12'd2700});
        end

        // Overflow: twenty strobes into a stalled sixteen-deep buffer.
        got.delete();
        d0 = done_cnt;
        m_ready = 1'b0;
        cmd(20, 0);
        for (int i = 0; i < 20; i++) sample(i * 7 + 3);
        chk("ovf_flag", overflow, 1'b1);
        m_ready = 1'b1;
        run_until_idle("ovf_idle", 60);
        chk("ovf_count", got.size(), 16);
        for (int i = 0; i < got.size(); i++) begin
            w = got[i];
            chk("ovf_word", w, {1'b0, 12'(i * 7 + 3)});
        end
        chk("ovf_done", done_cnt - d0, 1);
        chk("ovf_sticky", overflow, 1'b1);

        // Abort mid-capture, then a fresh command.
        d0 = done_cnt;
        m_ready = 1'b0;
        cmd(10, 0);
        sample(11); sample(22); sample(33);
        abort = 1'b1;
        adc_data_en = 1'b1;
        adc_data = 12'd44;
        cycle();
        abort = 1'b0;
        adc_data_en = 1'b0;
        cycle();
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", m_valid, 1'b0);
        chk("abort_nodone", done_cnt - d0, 0);
        got.delete();
        m_ready = 1'b1;
        cmd(2, 0);
        sample(55); sample(66);
        run_until_idle("post_abort_idle", 40);
        chk("post_abort_count", got.size(), 2);

        // Zero length: done right after acceptance, never busy.
        d0 = done_cnt;
        cmd(0, 0);
        cycle();
        cycle();
        chk("zero_done", done_cnt - d0, 1);

`ifdef ADC_CAPTURE_TIMEOUT_EN
        d0 = done_cnt;
        cmd(5, 4095);
        for (int i = 0; i < 105; i++) sample(2048);
        chk("to_flag", timeout, 1'b1);
        chk("to_busy", busy, 1'b0);
        chk("to_nodone", done_cnt - d0, 0);
`endif

        // Randomized traffic with backpressure, extremes, stray commands and aborts.
        for (int i = 0; i < 3000; i++) begin
            adc_data_en = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0: adc_data = 12'd0;
                1: adc_data = 12'd4095;
                2: adc_data = 12'd2048;
                default: adc_data = 12'($urandom);
            endcase
            m_ready = (i % 400 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            cmd_valid = ($urandom_range(0, 15) == 0);
            cmd_len = 16'($urandom_range(0, 24));
            case ($urandom_range(0, 2))
                0: cmd_thresh = 12'd0;
                1: cmd_thresh = 12'($urandom_range(0, 600));
                default: cmd_thresh = 12'($urandom_range(0, 2100));
            endcase
            abort = ($urandom_range(0, 199) == 0);
            cycle();
        end
        adc_data_en = 1'b0;
        cmd_valid = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        repeat (3) cycle();
        chk("final_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture sequencer for the 12-bit ADC sample stream produced by the AD7276 reader (one sample per 32 clk at 81.36 MHz). On a host command it arms a level trigger on the carrier envelope. It then gates a fixed-length window of samples into a 16-deep buffer and forwards the buffer on a valid/ready stream to the demodulator or debug dump path. It reports done, overflow and (optionally) arm timeout.

## Interface
Parameters:
- `LEN_W`, default 16: width of the window length field.
- `FIFO_DEPTH`, default 16: buffer depth; must be a power of two.
- `TIMEOUT_CYC`, default 32'd81_360_000: arm timeout in clk cycles (1 s). Used only with the macro defined.

Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- `clk` input 1: system clock, 81.36 MHz.
- `rst` input 1: asynchronous reset, active-high.
- `adc_data_en` input 1: one-cycle sample strobe.
- `adc_data` input 12: offset-binary sample; 2048 is mid-scale.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accepted when high together with `cmd_valid`.
- `cmd_len` input LEN_W: window length in samples.
- `cmd_thresh` input 12: trigger threshold on |sample−2048|.
- `abort` input 1: synchronous abort.
- `m_valid` output 1: output stream valid.
- `m_ready` input 1: output stream ready.
- `m_data` output 12: output sample.
- `m_last` output 1: marks the final sample of the window.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse when the window completes.
- `overflow` output 1: sticky flag; a sample was dropped.
- `timeout` output 1: sticky flag; the arm timed out. Tied to 0 without the macro.

## Operation
States are IDLE, ARMED, CAPTURE and DRAIN.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`:
  - latch `cmd_len` into `rem` and `cmd_thresh` into `thr`;
  - clear `overflow` and `timeout`;
  - if `cmd_len`=0, pulse `done` and stay in IDLE; otherwise go to ARMED.
- **ARMED:** on each `adc_data_en`, compute `dev` = |`adc_data`−2048| in 12-bit unsigned. The values 0 and 4095 both give a deviation of 2048 or 2047 with no wrap.
  - If `dev` ≥ `thr`, the triggering sample is the first window sample: push it, set `rem`−1, and go to CAPTURE.
  - If `rem`−1 = 0, go straight to DRAIN instead.
  - `thr`=0 triggers on the first sample.
- **CAPTURE:** each `adc_data_en` pushes `{last, data}` and decrements `rem`. The sample is tagged `last` when `rem`=1. Go to DRAIN when the `last` sample is pushed or dropped.
- **DRAIN:** wait until the FIFO is empty and there is no pending output. Then pulse `done` and go to IDLE.
- **Full FIFO:** a sample strobed while the FIFO is full (count = FIFO_DEPTH with no pop that cycle) is dropped.
  - Set `overflow`; `rem` still decrements.
  - If the dropped sample was `last`, no `m_last` is emitted for this window, and `done` still fires.
- **Abort:** `abort` from any non-IDLE state flushes the FIFO, sets `m_valid` to 0 and moves to IDLE on the next edge. No `done` pulse. Sticky flags are kept. `abort` in IDLE is ignored.
- **Abort priority:** `abort` takes priority over a same-cycle trigger or push.
- **Commands:** `cmd_valid` outside IDLE is ignored; `cmd_ready`=0 there.

## Timing
- **Reset values:** state IDLE, `cmd_ready`=1, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, `overflow`=0, `timeout`=0, FIFO empty, `rem`=0.
- **Command handshake:** the state changes on the edge after `cmd_valid`&`cmd_ready`. A sample strobed in the acceptance cycle itself is not evaluated.
- **Trigger:** evaluated combinationally in the strobe cycle; the FIFO write is registered on the same edge.
- **FIFO:** first-word-fall-through. `m_valid` rises on the clk edge after the push, so latency is 1 cycle from strobe to `m_valid`.
- **Output handshake:** transfer occurs on `m_valid`&`m_ready`. `m_data`/`m_last` hold stable while `m_valid`&!`m_ready`.
- **Simultaneous push and pop:** allowed when full; the count is unchanged and nothing is dropped.
- **`done` pulse:** asserted for 1 cycle on the edge after the last word leaves the FIFO.
- **Pointer wrap:** pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count is log2(FIFO_DEPTH)+1 bits.

## Configuration
- **Macro:** `ADC_CAPTURE_TIMEOUT_EN`.
- **Defined:**
  - a 32-bit counter clears on entering ARMED and increments every cycle in ARMED;
  - at TIMEOUT_CYC−1 with no trigger, set `timeout` and go to IDLE without a `done` pulse;
  - a trigger in the final cycle wins over the timeout.
- **Undefined:** ARMED waits indefinitely, the counter logic is absent and `timeout` is constant 0.

## Structure
- **Package `adc_capture_pkg`:**
  - `ADC_W`=12 and `ADC_MID`=12'd2048;
  - state enum `cap_state_t` with values IDLE, ARMED, CAPTURE and DRAIN;
  - the `abs_dev` function.
- **Sub-module `adc_sample_fifo`:** synchronous FWFT FIFO with width 13 (`{last, data}`) and depth FIFO_DEPTH, with a `flush` input. It is instantiated once.

## Test plan
- **Immediate trigger:** `cmd_len`=4, `cmd_thresh`=0, samples 100, 200, 300, 400, 500, `m_ready`=1 → outputs 100, 200, 300, 400; `m_last` on 400; `done` 1 cycle after 400 transfers; 500 not output.
- **Threshold:** `cmd_thresh`=500, samples 2048, 2400, 1500, 2700, 3000 with `cmd_len`=2 → trigger at 1500 (dev 548), outputs 1500, 2700, `m_last` on 2700.
- **Overflow:** `cmd_len`=20, `thr`=0, `m_ready`=0 → 16 words held and `overflow`=1. Release `m_ready` → 16 words out with no `m_last`, then `done`.
- **Abort:** `abort` in CAPTURE after 3 samples → next cycle `busy`=0, `m_valid`=0, no `done`. A new command then works normally.
- **Zero length:** `cmd_len`=0 → `done` pulses in the cycle after acceptance and `busy` stays 0.
- **Timeout (macro defined, TIMEOUT_CYC=100):** `thr`=4095, mid-scale samples → `timeout`=1 and IDLE after 100 cycles, no `done`.
